jt6295_fetch: RTL and testbench

- Upstream feeder of the ADPCM decoder stage.
- Holds playback state for four voice channels and fetches sample bytes from ROM through a rom_cs/rom_ok handshake.
- Splits each byte into 4-bit nibbles, high nibble first.
- Presents one channel per cen slot in fixed order 0,1,2,3 as data/en/att, which the decoder pipeline consumes directly.

---
 rtl/jt6295_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_jt6295_fetch.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_fetch.sv
// jt6295_fetch -- sample fetch front-end for a four-voice ADPCM decoder.
//
// Each voice streams ROM bytes from its start address to its stop address
// (inclusive, wrapping modulo 2^AW). A byte is split into two nibbles, high
// nibble first. One voice is presented per cen strobe in fixed order 0..3.
// ROM bytes are fetched at clk rate by a round-robin request engine.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cen               slot advance strobe (one voice slot per strobe)
//   start, stop       per-voice start / stop pulses
//   start_addr        first byte address, sampled with start
//   stop_addr         last byte address (inclusive), sampled with start
//   start_att         attenuation code, sampled with start
//   busy              per-voice playing flags
//   underrun          sticky per-voice empty-buffer flags, cleared by start
//   rom_addr, rom_cs  ROM request address / strobe
//   rom_data, rom_ok  ROM byte and its valid flag
//   data, en, att     nibble, nibble-valid and attenuation for this slot
//   slot              voice index of data/en/att
module jt6295_fetch #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [3:0]    start,
  input  logic [3:0]    stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] stop_addr,
  input  logic [3:0]    start_att,
  output logic [3:0]    busy,
  output logic [3:0]    underrun,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    data,
  output logic          en,
  output logic [3:0]    att,
  output logic [1:0]    slot
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0] ch_addr [4];
  logic [AW-1:0] ch_stop [4];
  logic [3:0]    ch_att  [4];
  logic [7:0]    ch_buf  [4];
  logic [3:0]    nib;
  logic [3:0]    valid;
  logic [3:0]    active;

  logic [1:0]    s;
  logic [1:0]    rr;
  logic [1:0]    fch;
  logic [AW-1:0] fch_addr;

  logic [3:0]    need;
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          pick_found;
  logic          abort;
  logic          capture;
  logic          take;

  assign busy = active;

  // A voice being stopped this cycle is not worth fetching for.
  assign need = active & ~valid & ~stop;

  // Current slot consumes a nibble; a same-cycle stop wins over consumption.
  assign take = active[s] & valid[s] & ~stop[s];

  // Any start/stop aimed at the voice being fetched cancels the request.
  assign abort   = (state != ST_IDLE) && (start[fch] || stop[fch]);
  assign capture = (state == ST_WAIT) && rom_ok && !abort;

  // Round-robin search starting at rr.
  always_comb begin
    pick_found = 1'b0;
    pick       = rr;
    idx        = rr;
    for (int k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!pick_found && need[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  // Fetch FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fch      <= 2'd0;
      fch_addr <= '0;
      rr       <= 2'd0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && pick_found) begin
        fch      <= pick;
        fch_addr <= ch_addr[pick];
      end
      if (capture) rr <= fch + 2'd1;
    end
  end

  // Fetch FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (pick_found) state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT:   if (abort || rom_ok) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Fetch FSM: outputs. Address is held for the whole request because
  // fch_addr only reloads in IDLE.
  always_comb begin
    rom_cs   = (state == ST_SETTLE) || (state == ST_WAIT);
    rom_addr = fch_addr;
  end

  // Per-voice state. Later assignments take priority:
  // stop > start > slot consumption / ROM capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        ch_addr[i] <= '0;
        ch_stop[i] <= '0;
        ch_att[i]  <= 4'd0;
        ch_buf[i]  <= 8'd0;
      end
      nib      <= 4'd0;
      valid    <= 4'd0;
      active   <= 4'd0;
      underrun <= 4'd0;
    end else begin
      if (cen) begin
        if (take) begin
          nib[s] <= ~nib[s];
          if (nib[s]) begin
            valid[s] <= 1'b0;
            if (ch_addr[s] == ch_stop[s]) active[s] <= 1'b0;
            else                          ch_addr[s] <= ch_addr[s] + AW'(1);
          end
        end else if (active[s] && !stop[s]) begin
          underrun[s] <= 1'b1;
        end
      end

      if (capture) begin
        ch_buf[fch] <= rom_data;
        valid[fch]  <= 1'b1;
      end

      for (int i = 0; i < 4; i++) begin
        if (start[i] && !active[i] && !stop[i]) begin
          ch_addr[i]  <= start_addr;
          ch_stop[i]  <= stop_addr;
          ch_att[i]   <= start_att;
          nib[i]      <= 1'b0;
          valid[i]    <= 1'b0;
          active[i]   <= 1'b1;
          underrun[i] <= 1'b0;
        end
        if (stop[i]) begin
          active[i] <= 1'b0;
          valid[i]  <= 1'b0;
        end
      end
    end
  end

  // Slot output registers, loaded on each cen for voice s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= 2'd0;
      slot <= 2'd0;
      att  <= 4'd0;
      data <= 4'd0;
      en   <= 1'b0;
    end else if (cen) begin
      s    <= s + 2'd1;
      slot <= s;
      att  <= ch_att[s];
      if (take) begin
        en   <= 1'b1;
        data <= nib[s] ? ch_buf[s][3:0] : ch_buf[s][7:4];
      end else begin
        en   <= 1'b0;
        data <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_jt6295_fetch.sv
// Directed bench for jt6295_fetch: a behavioural ROM answers requests,
// a monitor logs every cen slot, and each test task checks the log and
// DUT outputs against hand-computed values.
module tb_jt6295_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic [3:0]  start = 4'd0;
  logic [3:0]  stop = 4'd0;
  logic [17:0] start_addr = '0;
  logic [17:0] stop_addr = '0;
  logic [3:0]  start_att = 4'd0;
  logic [3:0]  busy;
  logic [3:0]  underrun;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic [3:0]  data;
  logic        en;
  logic [3:0]  att;
  logic [1:0]  slot;

  int checks = 0;
  int failures = 0;

  jt6295_fetch #(.AW(18)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .start(start), .stop(stop),
    .start_addr(start_addr), .stop_addr(stop_addr), .start_att(start_att),
    .busy(busy), .underrun(underrun),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .data(data), .en(en), .att(att), .slot(slot)
  );

  initial forever #5 clk = ~clk;

  // cen: one clk out of every 8
  int ccnt = 0;
  initial forever begin
    @(posedge clk); #3;
    cen  = (ccnt == 7);
    ccnt = (ccnt + 1) % 8;
  end

  // ROM model
  int          rom_lat = 2;
  logic        rom_hold = 1'b0;
  logic        use_seq = 1'b0;
  logic [7:0]  seq [4];
  logic [17:0] req_q [$];
  int          cs_cnt = 0;

  function automatic logic [7:0] mem_byte(input logic [17:0] a);
    case (a)
      18'h00100: return 8'hA5;
      18'h00101: return 8'h3C;
      18'h3FFFF: return 8'h12;
      18'h00000: return 8'h34;
      18'h00300: return 8'h9E;
      18'h00600: return 8'h6B;
      18'h00700: return 8'hF0;
      default:   return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  initial begin
    rom_ok = 1'b0;
    rom_data = 8'd0;
    forever begin
      @(posedge clk); #2;
      if (rom_cs === 1'b1) begin
        cs_cnt++;
        if (cs_cnt == 1) req_q.push_back(rom_addr);
        rom_data = use_seq ? seq[(req_q.size() - 1) % 4] : mem_byte(rom_addr);
        rom_ok   = (cs_cnt >= rom_lat) && !rom_hold;
      end else begin
        cs_cnt = 0;
        rom_ok = 1'b0;
      end
    end
  end

  // Slot monitor
  typedef struct packed {
    logic [1:0] slot;
    logic       en;
    logic [3:0] data;
    logic [3:0] att;
    logic [3:0] busy;
  } ent_t;
  ent_t log_q [$];
  logic mon_cen;

  initial forever begin
    @(posedge clk);
    mon_cen = cen;
    #1;
    if (mon_cen && rst_n) log_q.push_back({slot, en, data, att, busy});
  end

  logic [3:0] nq [$];
  logic [3:0] aq [$];
  logic [3:0] bq [$];

  task automatic collect(input int k);
    nq.delete(); aq.delete(); bq.delete();
    foreach (log_q[i]) begin
      if (log_q[i].slot == 2'(k) && log_q[i].en) begin
        nq.push_back(log_q[i].data);
        aq.push_back(log_q[i].att);
        bq.push_back(log_q[i].busy);
      end
    end
  endtask

  function automatic logic [15:0] pack_nibs();
    logic [15:0] v = 16'd0;
    foreach (nq[i]) v = {v[11:0], nq[i]};
    return v;
  endfunction

  function automatic int count_en();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].en) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_cen(input int n);
    repeat (n * 8) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 4'd0;
    stop = 4'd0;
    rom_hold = 1'b0;
    use_seq = 1'b0;
    rom_lat = 2;
    repeat (2) @(posedge clk);
    log_q.delete();
    req_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input logic [3:0] m, input logic [17:0] sa,
                             input logic [17:0] ea, input logic [3:0] at);
    start_addr = sa;
    stop_addr  = ea;
    start_att  = at;
    start      = m;
    tick();
    start      = 4'd0;
  endtask

  task automatic pulse_stop(input logic [3:0] m);
    stop = m;
    tick();
    stop = 4'd0;
  endtask

  task automatic wait_cs();
    int n = 0;
    while (rom_cs !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (rom_cs !== 1'b1) begin
      failures++;
      $display("FAIL wait_cs: rom_cs=%b after %0d cycles, required 1", rom_cs, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 4'd0)     begin failures++; $display("FAIL reset_busy: got %h required 0", busy); end
    checks++; if (underrun !== 4'd0) begin failures++; $display("FAIL reset_underrun: got %h required 0", underrun); end
    checks++; if (rom_cs !== 1'b0)   begin failures++; $display("FAIL reset_rom_cs: got %b required 0", rom_cs); end
    checks++; if (rom_addr !== 18'd0) begin failures++; $display("FAIL reset_rom_addr: got %h required 0", rom_addr); end
    checks++; if (data !== 4'd0)     begin failures++; $display("FAIL reset_data: got %h required 0", data); end
    checks++; if (en !== 1'b0)       begin failures++; $display("FAIL reset_en: got %b required 0", en); end
    checks++; if (att !== 4'd0)      begin failures++; $display("FAIL reset_att: got %h required 0", att); end
    checks++; if (slot !== 2'd0)     begin failures++; $display("FAIL reset_slot: got %h required 0", slot); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    rom_hold = 1'b1;
    pulse_start(4'b0001, 18'h100, 18'h101, 4'd3);
    wait_cs();
    repeat (2) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (rom_cs !== 1'b0) begin failures++; $display("FAIL midrst_rom_cs: got %b required 0", rom_cs); end
    checks++; if (busy !== 4'd0)   begin failures++; $display("FAIL midrst_busy: got %h required 0", busy); end
    checks++; if (en !== 1'b0 || slot !== 2'd0) begin failures++; $display("FAIL midrst_out: en=%b slot=%h required 0/0", en, slot); end
    rom_hold = 1'b0;
    repeat (2) @(posedge clk);
    log_q.delete();
    req_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_cen(4);
    checks++; if (req_q.size() !== 0) begin failures++; $display("FAIL midrst_no_req: got %0d requests required 0", req_q.size()); end
    checks++; if (busy !== 4'd0 || count_en() !== 0) begin failures++; $display("FAIL midrst_idle: busy=%h en_count=%0d required 0/0", busy, count_en()); end
  endtask

  task automatic test_single();
    do_reset();
    pulse_start(4'b0001, 18'h100, 18'h101, 4'd3);
    run_cen(32);
    collect(0);
    checks++; if (nq.size() !== 4 || pack_nibs() !== 16'hA53C) begin failures++; $display("FAIL single_nibbles: got %0d nibbles %h required 4 nibbles A53C", nq.size(), pack_nibs()); end
    checks++; if (aq.size() !== 4 || {aq[0], aq[1], aq[2], aq[3]} !== 16'h3333) begin failures++; $display("FAIL single_att: got %0d entries required att 3 on 4", aq.size()); end
    checks++; if (bq.size() !== 4 || bq[2][0] !== 1'b1 || bq[3][0] !== 1'b0) begin failures++; $display("FAIL single_busy_fall: busy before/at last nibble not 1/0"); end
    checks++; if (count_en() !== 4) begin failures++; $display("FAIL single_other_en: got %0d en slots required 4", count_en()); end
    checks++; if (req_q.size() !== 2 || req_q[0] !== 18'h100 || req_q[1] !== 18'h101) begin failures++; $display("FAIL single_req: got %0d requests required 100,101", req_q.size()); end
  endtask

  task automatic test_four_channels();
    int bad = 0;
    logic [7:0] got;
    do_reset();
    use_seq = 1'b1;
    seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56; seq[3] = 8'h78;
    pulse_start(4'b1111, 18'h200, 18'h200, 4'd5);
    run_cen(20);
    for (int k = 0; k < 4; k++) begin
      collect(k);
      got = pack_nibs()[7:0];
      checks++;
      if (nq.size() !== 2 || got !== seq[k]) begin
        failures++;
        $display("FAIL four_ch%0d: got %0d nibbles %h required 2 nibbles %h", k, nq.size(), got, seq[k]);
      end
    end
    foreach (log_q[i]) if (log_q[i].slot !== 2'(i % 4)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL four_slot_order: got %0d out-of-order slots required 0", bad); end
    checks++; if (busy !== 4'd0 || req_q.size() !== 4) begin failures++; $display("FAIL four_done: busy=%h requests=%0d required 0/4", busy, req_q.size()); end
    use_seq = 1'b0;
  endtask

  task automatic test_underrun();
    do_reset();
    rom_hold = 1'b1;
    pulse_start(4'b0010, 18'h300, 18'h300, 4'd7);
    run_cen(20);
    checks++; if (underrun !== 4'b0010) begin failures++; $display("FAIL underrun_flag: got %h required 2", underrun); end
    checks++; if (count_en() !== 0 || busy !== 4'b0010) begin failures++; $display("FAIL underrun_silent: en_count=%0d busy=%h required 0/2", count_en(), busy); end
    checks++; if (rom_cs !== 1'b1 || rom_addr !== 18'h300) begin failures++; $display("FAIL underrun_addr: cs=%b addr=%h required 1/300", rom_cs, rom_addr); end
    rom_hold = 1'b0;
    run_cen(12);
    collect(1);
    checks++; if (nq.size() !== 2 || pack_nibs() !== 16'h009E) begin failures++; $display("FAIL underrun_resume: got %0d nibbles %h required 9E", nq.size(), pack_nibs()); end
    checks++; if (busy !== 4'd0 || underrun !== 4'b0010) begin failures++; $display("FAIL underrun_sticky: busy=%h underrun=%h required 0/2", busy, underrun); end
    pulse_start(4'b0010, 18'h300, 18'h300, 4'd7);
    checks++; if (underrun[1] !== 1'b0) begin failures++; $display("FAIL underrun_clear: got %b required 0", underrun[1]); end
  endtask

  task automatic test_stop_abort();
    do_reset();
    rom_hold = 1'b1;
    pulse_start(4'b0100, 18'h400, 18'h40F, 4'd1);
    wait_cs();
    repeat (3) tick();
    rom_hold = 1'b0;
    pulse_stop(4'b0100);
    checks++; if (rom_cs !== 1'b0 || busy !== 4'd0) begin failures++; $display("FAIL abort_now: cs=%b busy=%h required 0/0", rom_cs, busy); end
    run_cen(10);
    checks++; if (count_en() !== 0 || req_q.size() !== 1) begin failures++; $display("FAIL abort_discard: en_count=%0d requests=%0d required 0/1", count_en(), req_q.size()); end
  endtask

  task automatic test_start_stop_same();
    do_reset();
    start_addr = 18'h500; stop_addr = 18'h500; start_att = 4'd4;
    start = 4'b0010;
    stop  = 4'b0010;
    tick();
    start = 4'd0;
    stop  = 4'd0;
    checks++; if (busy !== 4'd0) begin failures++; $display("FAIL startstop_busy: got %h required 0", busy); end
    run_cen(4);
    checks++; if (req_q.size() !== 0 || count_en() !== 0) begin failures++; $display("FAIL startstop_idle: requests=%0d en_count=%0d required 0/0", req_q.size(), count_en()); end
  endtask

  task automatic test_start_busy();
    do_reset();
    rom_hold = 1'b1;
    pulse_start(4'b1000, 18'h600, 18'h600, 4'd2);
    repeat (5) tick();
    pulse_start(4'b1000, 18'h700, 18'h700, 4'd9);
    rom_hold = 1'b0;
    run_cen(16);
    collect(3);
    checks++; if (nq.size() !== 2 || pack_nibs() !== 16'h006B) begin failures++; $display("FAIL busy_start_data: got %0d nibbles %h required 6B", nq.size(), pack_nibs()); end
    checks++; if (aq.size() !== 2 || aq[0] !== 4'd2 || aq[1] !== 4'd2) begin failures++; $display("FAIL busy_start_att: got %0d entries required att 2", aq.size()); end
    begin
      int bad = 0;
      foreach (req_q[i]) if (req_q[i] !== 18'h600) bad++;
      checks++; if (bad !== 0 || req_q.size() == 0) begin failures++; $display("FAIL busy_start_addr: %0d requests not at 600 of %0d", bad, req_q.size()); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    pulse_start(4'b0001, 18'h3FFFF, 18'h00000, 4'd6);
    run_cen(32);
    collect(0);
    checks++; if (req_q.size() !== 2 || req_q[0] !== 18'h3FFFF || req_q[1] !== 18'h00000) begin failures++; $display("FAIL wrap_addr: got %0d requests required 3FFFF,00000", req_q.size()); end
    checks++; if (nq.size() !== 4 || pack_nibs() !== 16'h1234) begin failures++; $display("FAIL wrap_nibbles: got %0d nibbles %h required 1234", nq.size(), pack_nibs()); end
    checks++; if (busy !== 4'd0) begin failures++; $display("FAIL wrap_busy: got %h required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fetch();
    test_single();
    test_four_channels();
    test_underrun();
    test_stop_abort();
    test_start_stop_same();
    test_start_busy();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
